// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_if
// Brief    : ID/EX-side inputs and EX/MEM-side registered outputs of ex_stage
// Revision : 1.0
// ============================================================================
interface ex_stage_if;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [31:0] npc;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] s_extend;
    logic [4:0]  instr_2016;
    logic [4:0]  instr_1511;

    logic [1:0]  wb_ctl_out;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2_out;
    logic [31:0] add_result;
    logic [4:0]  dest_reg;

    modport master (
        output wb_ctl, m_ctl, regdst, alusrc, aluop, npc, rdata1, rdata2,
               s_extend, instr_2016, instr_1511,
        input  wb_ctl_out, branch, memread, memwrite, zero, alu_result,
               rdata2_out, add_result, dest_reg
    );

    modport slave (
        input  wb_ctl, m_ctl, regdst, alusrc, aluop, npc, rdata1, rdata2,
               s_extend, instr_2016, instr_1511,
        output wb_ctl_out, branch, memread, memwrite, zero, alu_result,
               rdata2_out, add_result, dest_reg
    );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : MIPS-subset execute stage (ALU, branch adder) with EX/MEM register.
//            Define BRANCH_WORD_SHIFT_EN for a word-offset branch target.
// Revision : 1.0
// ============================================================================
module ex_stage (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);
    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_inv = 3'b011;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_slt = 3'b111;

    logic [2:0]  w_alu_sel;
    logic [31:0] w_op_b;
    logic [31:0] w_alu_result;
    logic [31:0] w_branch_offset;
    logic [31:0] w_add_result;
    logic [4:0]  w_dest_reg;

    logic [1:0]  r_wb_ctl;
    logic [2:0]  r_m_ctl;
    logic        r_zero;
    logic [31:0] r_alu_result;
    logic [31:0] r_rdata2;
    logic [31:0] r_add_result;
    logic [4:0]  r_dest_reg;

`ifdef BRANCH_WORD_SHIFT_EN
    assign w_branch_offset = {bus.s_extend[29:0], 2'b00};
`else
    assign w_branch_offset = bus.s_extend;
`endif
    assign w_add_result = bus.npc + w_branch_offset;

    always_comb begin
        w_alu_sel = c_alu_add;
        case (bus.aluop)
            2'b01: w_alu_sel = c_alu_sub;
            2'b10: begin
                case (bus.s_extend[5:0])
                    6'b100000: w_alu_sel = c_alu_add;
                    6'b100010: w_alu_sel = c_alu_sub;
                    6'b100100: w_alu_sel = c_alu_and;
                    6'b100101: w_alu_sel = c_alu_or;
                    6'b101010: w_alu_sel = c_alu_slt;
                    default:   w_alu_sel = c_alu_inv;
                endcase
            end
            default: w_alu_sel = c_alu_add;
        endcase
    end

    assign w_op_b = bus.alusrc ? bus.s_extend : bus.rdata2;

    always_comb begin
        w_alu_result = 32'd0;
        case (w_alu_sel)
            c_alu_and: w_alu_result = bus.rdata1 & w_op_b;
            c_alu_or:  w_alu_result = bus.rdata1 | w_op_b;
            c_alu_add: w_alu_result = bus.rdata1 + w_op_b;
            c_alu_sub: w_alu_result = bus.rdata1 - w_op_b;
            c_alu_slt: w_alu_result = {31'd0, $signed(bus.rdata1) < $signed(w_op_b)};
            default:   w_alu_result = 32'd0;
        endcase
    end

    assign w_dest_reg = bus.regdst ? bus.instr_1511 : bus.instr_2016;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_ctl     <= 2'd0;
            r_m_ctl      <= 3'd0;
            r_zero       <= 1'b0;
            r_alu_result <= 32'd0;
            r_rdata2     <= 32'd0;
            r_add_result <= 32'd0;
            r_dest_reg   <= 5'd0;
        end else begin
            r_wb_ctl     <= bus.wb_ctl;
            r_m_ctl      <= bus.m_ctl;
            r_zero       <= (w_alu_result == 32'd0);
            r_alu_result <= w_alu_result;
            r_rdata2     <= bus.rdata2;
            r_add_result <= w_add_result;
            r_dest_reg   <= w_dest_reg;
        end
    end

    assign bus.wb_ctl_out = r_wb_ctl;
    assign bus.branch     = r_m_ctl[2];
    assign bus.memread    = r_m_ctl[1];
    assign bus.memwrite   = r_m_ctl[0];
    assign bus.zero       = r_zero;
    assign bus.alu_result = r_alu_result;
    assign bus.rdata2_out = r_rdata2;
    assign bus.add_result = r_add_result;
    assign bus.dest_reg   = r_dest_reg;
endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Directed self-checking bench for ex_stage (honours BRANCH_WORD_SHIFT_EN)
// Revision : 1.0
// ============================================================================
module tb_ex_stage;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    ex_stage_if u_if ();

    ex_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] wb, input logic br,
                             input logic mr, input logic mw, input logic z,
                             input logic [31:0] alu, input logic [31:0] r2,
                             input logic [31:0] add, input logic [4:0] dest);
        check({tag, ".wb_ctl_out"}, {30'd0, u_if.wb_ctl_out}, {30'd0, wb});
        check({tag, ".branch"},     {31'd0, u_if.branch},     {31'd0, br});
        check({tag, ".memread"},    {31'd0, u_if.memread},    {31'd0, mr});
        check({tag, ".memwrite"},   {31'd0, u_if.memwrite},   {31'd0, mw});
        check({tag, ".zero"},       {31'd0, u_if.zero},       {31'd0, z});
        check({tag, ".alu_result"}, u_if.alu_result, alu);
        check({tag, ".rdata2_out"}, u_if.rdata2_out, r2);
        check({tag, ".add_result"}, u_if.add_result, add);
        check({tag, ".dest_reg"},   {27'd0, u_if.dest_reg},   {27'd0, dest});
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic rd_sel,
                         input logic src, input logic [1:0] op, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] sx,
                         input logic [4:0] rt, input logic [4:0] rd);
        u_if.wb_ctl     = wb;
        u_if.m_ctl      = m;
        u_if.regdst     = rd_sel;
        u_if.alusrc     = src;
        u_if.aluop      = op;
        u_if.npc        = pc;
        u_if.rdata1     = a;
        u_if.rdata2     = b;
        u_if.s_extend   = sx;
        u_if.instr_2016 = rt;
        u_if.instr_1511 = rd;
    endtask

    task automatic drive_random();
        drive(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
              $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        drive_random();

        // Asynchronous clear checked before the first clock edge
        #2 rst_n = 1'b0;
        #1 check_all("rst_async", 2'b00, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0);
        repeat (2) begin
            @(negedge clk);
            drive_random();
            step();
        end
        check_all("rst_hold", 2'b00, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0);

        // R-type add, loaded by the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b10, 3'b000, 1, 0, 2'b10, 32'h100, 32'd7, 32'd5, 32'h20, 5'd8, 5'd3);
        step();
`ifdef BRANCH_WORD_SHIFT_EN
        check_all("radd", 2'b10, 0, 0, 0, 0, 32'd12, 32'd5, 32'h180, 5'd3);
`else
        check_all("radd", 2'b10, 0, 0, 0, 0, 32'd12, 32'd5, 32'h120, 5'd3);
`endif

        @(negedge clk);
        drive(2'b00, 3'b100, 0, 0, 2'b01, 32'd4, 32'h1234, 32'h1234, 32'h10, 5'd1, 5'd2);
        step();
`ifdef BRANCH_WORD_SHIFT_EN
        check_all("beq", 2'b00, 1, 0, 0, 1, 32'd0, 32'h1234, 32'd68, 5'd1);
`else
        check_all("beq", 2'b00, 1, 0, 0, 1, 32'd0, 32'h1234, 32'd20, 5'd1);
`endif

        @(negedge clk);
        drive(2'b11, 3'b010, 0, 1, 2'b00, 32'h40, 32'd100, 32'hDEADBEEF, 32'hFFFFFFFC, 5'd9, 5'd4);
        step();
`ifdef BRANCH_WORD_SHIFT_EN
        check_all("lw", 2'b11, 0, 1, 0, 0, 32'd96, 32'hDEADBEEF, 32'h30, 5'd9);
`else
        check_all("lw", 2'b11, 0, 1, 0, 0, 32'd96, 32'hDEADBEEF, 32'h3C, 5'd9);
`endif

        @(negedge clk);
        drive(2'b10, 3'b000, 1, 0, 2'b10, 32'd0, 32'hF0F0, 32'h0FF0, 32'h24, 5'd0, 5'd5);
        step();
        check("and.alu", u_if.alu_result, 32'h00F0);
        check("and.zero", {31'd0, u_if.zero}, 32'd0);

        @(negedge clk);
        u_if.s_extend = 32'h25;
        step();
        check("or.alu", u_if.alu_result, 32'hFFF0);

        @(negedge clk);
        drive(2'b10, 3'b000, 1, 0, 2'b10, 32'd0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd0, 5'd6);
        step();
        check("slt_lt.alu", u_if.alu_result, 32'd1);
        check("slt_lt.zero", {31'd0, u_if.zero}, 32'd0);

        @(negedge clk);
        drive(2'b10, 3'b000, 1, 0, 2'b10, 32'd0, 32'd1, 32'hFFFFFFFF, 32'h2A, 5'd0, 5'd6);
        step();
        check("slt_ge.alu", u_if.alu_result, 32'd0);
        check("slt_ge.zero", {31'd0, u_if.zero}, 32'd1);

        @(negedge clk);
        drive(2'b10, 3'b000, 1, 0, 2'b10, 32'd0, 32'd3, 32'd5, 32'h22, 5'd0, 5'd7);
        step();
        check("sub.alu", u_if.alu_result, 32'hFFFFFFFE);

        @(negedge clk);
        drive(2'b11, 3'b000, 0, 0, 2'b10, 32'd0, 32'd5, 32'd5, 32'h0, 5'd10, 5'd11);
        step();
        check("inv.alu", u_if.alu_result, 32'd0);
        check("inv.zero", {31'd0, u_if.zero}, 32'd1);
        check("inv.wb", {30'd0, u_if.wb_ctl_out}, 32'd3);
        check("inv.dest", {27'd0, u_if.dest_reg}, 32'd10);

        // aluop 11 adds with wraparound; rdata2_out ignores alusrc
        @(negedge clk);
        drive(2'b01, 3'b001, 0, 1, 2'b11, 32'hFFFFFFF0, 32'h7FFFFFFF, 32'h55AA55AA, 32'd1, 5'd12, 5'd13);
        step();
`ifdef BRANCH_WORD_SHIFT_EN
        check_all("sw", 2'b01, 0, 0, 1, 0, 32'h80000000, 32'h55AA55AA, 32'hFFFFFFF4, 5'd12);
`else
        check_all("sw", 2'b01, 0, 0, 1, 0, 32'h80000000, 32'h55AA55AA, 32'hFFFFFFF1, 5'd12);
`endif

        // Mid-cycle reset assertion clears immediately
        #2 rst_n = 1'b0;
        #1 check_all("rst_mid", 2'b00, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
